// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment capture checker: segment patterns
// (active-low, bit 0 = a ... bit 6 = g) and FSM state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0011000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    typedef enum logic {
        SETTLE,
        HOLD
    } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the display encoder: one 7-bit segment pattern
// to {legal, is_blank, nibble}. Blank is reported separately, not as legal.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic       is_blank,
    output logic [3:0] nibble
);

    always_comb begin
        legal    = 1'b1;
        is_blank = 1'b0;
        nibble   = 4'h0;
        case (seg)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: begin
                legal    = 1'b0;
                is_blank = 1'b1;
            end
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture_checker.sv
// Monitor for a two-digit seven-segment display: synchronises the segment
// buses, waits for them to settle, decodes the count and flags bad codes/steps.
module seg7_capture_checker
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter bit          CHECK_SEQ     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  hex0,
    input  logic [6:0]  hex1,
    output logic [7:0]  value,
    output logic        valid,
    output logic        code_err,
    output logic        seq_err,
    output logic        blank,
    output logic [15:0] capture_cnt
);

    localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

    logic [13:0] sync_q [SYNC_STAGES];
    logic [13:0] s;
    logic [13:0] s_prev;
    logic        same;
    logic [7:0]  stab_cnt;
    logic        have_prev;
    state_t      state;

    logic        d0_legal, d0_blank;
    logic        d1_legal, d1_blank;
    logic [3:0]  d0_nib, d1_nib;
    logic [7:0]  new_value;

    // Sync chain resets to all ones so the idle bus reads as blank.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '1;
            end
        end else begin
            sync_q[0] <= {hex1, hex0};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s         = sync_q[SYNC_STAGES-1];
    assign same      = (s == s_prev);
    assign new_value = {d1_nib, d0_nib};

    seg7_decode u_dec0 (
        .seg      (s[6:0]),
        .legal    (d0_legal),
        .is_blank (d0_blank),
        .nibble   (d0_nib)
    );

    seg7_decode u_dec1 (
        .seg      (s[13:7]),
        .legal    (d1_legal),
        .is_blank (d1_blank),
        .nibble   (d1_nib)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_prev      <= '1;
            stab_cnt    <= '0;
            have_prev   <= 1'b0;
            state       <= SETTLE;
            value       <= '0;
            valid       <= 1'b0;
            code_err    <= 1'b0;
            seq_err     <= 1'b0;
            blank       <= 1'b0;
            capture_cnt <= '0;
        end else begin
            valid    <= 1'b0;
            code_err <= 1'b0;
            seq_err  <= 1'b0;
            s_prev   <= s;
            case (state)
                SETTLE: begin
                    if (!same) begin
                        stab_cnt <= '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        state <= HOLD;
                        // Both-blank must be tested before legality, since a
                        // blank digit on its own counts as illegal.
                        if (d1_blank && d0_blank) begin
                            blank <= 1'b1;
                        end else if (!(d1_legal && d0_legal)) begin
                            code_err <= 1'b1;
                        end else begin
                            value     <= new_value;
                            valid     <= 1'b1;
                            blank     <= 1'b0;
                            have_prev <= 1'b1;
                            seq_err   <= CHECK_SEQ && have_prev &&
                                         (new_value != 8'(value + 8'd1));
                            if (capture_cnt != '1) begin
                                capture_cnt <= capture_cnt + 16'd1;
                            end
                        end
                    end else begin
                        stab_cnt <= stab_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (!same) begin
                        stab_cnt <= '0;
                        state    <= SETTLE;
                    end
                end
                default: begin
                    stab_cnt <= '0;
                    state    <= SETTLE;
                end
            endcase
        end
    end

endmodule
